// File: rtl/sdram_init_mon.sv
// sdram_init_mon: device-side checker for the SDRAM power-up init command stream.
// The bus is sampled every init_clk edge. This monitor checks the command
// order (PRE-all, then CNT_AR or more auto refreshes, then MRS) and the NOP
// spacing between commands. It decodes the programmed mode register and
// reports either init completion or the first violation it sees.
// Bus semantics: there is no valid/ready handshake. The monitor samples
// every edge. A NOP or a deselect (cmd[3]=1) is an idle cycle. Any other
// code is a command that is qualified on that edge.
module sdram_init_mon #(
   parameter int unsigned CNT_WAIT = 20000,
   parameter int unsigned CNT_AR   = 2,
   parameter int unsigned TRP      = 2,
   parameter int unsigned TRFC     = 7,
   parameter int unsigned TMRD     = 2
) (
   input  logic        init_clk,
   input  logic        init_rst_n,
   input  logic [3:0]  init_cmd,
   input  logic [1:0]  init_bank,
   input  logic [12:0] init_addr,
   output logic        mon_done,
   output logic        mon_err,
   output logic [2:0]  mon_err_code,
   output logic [3:0]  mon_ar_cnt,
   output logic        mon_mode_valid,
   output logic [2:0]  mon_burst_len,
   output logic        mon_burst_type,
   output logic [2:0]  mon_cas_lat,
   output logic        mon_wr_single,
   output logic [2:0]  mon_state
);

   typedef enum logic [2:0] {
      S_EXP_PRE   = 3'd0,
      S_EXP_AR    = 3'd1,
      S_AR_LOOP   = 3'd2,
      S_TMRD_WAIT = 3'd3,
      S_DONE      = 3'd4,
      S_ERR       = 3'd5
   } state_t;

   localparam logic [15:0] L_CNT_WAIT = 16'(CNT_WAIT);
   localparam logic [3:0]  L_CNT_AR   = 4'(CNT_AR);
   localparam logic [3:0]  L_TRP      = 4'(TRP);
   localparam logic [3:0]  L_TRFC     = 4'(TRFC);
   localparam logic [3:0]  L_TMRD     = 4'(TMRD);

   localparam logic [2:0] E_ILLEGAL = 3'd1;
   localparam logic [2:0] E_EARLY   = 3'd2;
   localparam logic [2:0] E_SEQ     = 3'd3;
   localparam logic [2:0] E_TIMING  = 3'd4;
   localparam logic [2:0] E_MRS_FMT = 3'd5;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_pu_cnt;
   logic [3:0]  r_gap_cnt;
   logic [3:0]  w_gap_nxt;
   logic [3:0]  r_ar_cnt;
   logic        r_done;
   logic        r_err;
   logic [2:0]  r_err_code;
   logic        r_mode_valid;
   logic [2:0]  r_burst_len;
   logic        r_burst_type;
   logic [2:0]  r_cas_lat;
   logic        r_wr_single;

   logic        w_is_nop, w_is_pre, w_is_ar, w_is_mrs, w_illegal;
   logic        w_early, w_fmt_bad;
   logic        w_err_hit, w_ar_inc, w_mode_ld, w_done_set;
   logic [2:0]  w_err_code;

   // Command decode and the idle-gap counter's next value
   always_comb begin
      w_is_nop  = init_cmd[3] || (init_cmd == 4'b0111);
      w_is_pre  = (init_cmd == 4'b0010);
      w_is_ar   = (init_cmd == 4'b0001);
      w_is_mrs  = (init_cmd == 4'b0000);
      w_illegal = !w_is_nop && !w_is_pre && !w_is_ar && !w_is_mrs;
      w_early   = (r_pu_cnt < L_CNT_WAIT);
      w_fmt_bad = (|init_bank) || (|init_addr[12:10]) || (|init_addr[8:7]);
      w_gap_nxt = 4'd0;
      if (w_is_nop) w_gap_nxt = (r_gap_cnt == 4'hF) ? 4'hF : r_gap_cnt + 4'd1;
   end

   // Next-state logic; checks are ordered so the lowest error code wins
   always_comb begin
      w_state_nxt = r_state;
      w_err_hit   = 1'b0;
      w_err_code  = 3'd0;
      w_ar_inc    = 1'b0;
      w_mode_ld   = 1'b0;
      w_done_set  = 1'b0;
      case (r_state)
         S_EXP_PRE: if (!w_is_nop) begin
            if (w_illegal)                        begin w_err_hit = 1'b1; w_err_code = E_ILLEGAL; end
            else if (w_early)                     begin w_err_hit = 1'b1; w_err_code = E_EARLY;   end
            else if (!w_is_pre || !init_addr[10]) begin w_err_hit = 1'b1; w_err_code = E_SEQ;     end
            else                                  w_state_nxt = S_EXP_AR;
         end
         S_EXP_AR: if (!w_is_nop) begin
            if (w_illegal)              begin w_err_hit = 1'b1; w_err_code = E_ILLEGAL; end
            else if (!w_is_ar)          begin w_err_hit = 1'b1; w_err_code = E_SEQ;     end
            else if (r_gap_cnt < L_TRP) begin w_err_hit = 1'b1; w_err_code = E_TIMING;  end
            else begin
               w_ar_inc    = 1'b1;
               w_state_nxt = S_AR_LOOP;
            end
         end
         S_AR_LOOP: if (!w_is_nop) begin
            if (w_illegal) begin
               w_err_hit = 1'b1; w_err_code = E_ILLEGAL;
            end else if (w_is_pre || (w_is_mrs && (r_ar_cnt < L_CNT_AR))) begin
               w_err_hit = 1'b1; w_err_code = E_SEQ;
            end else if (r_gap_cnt < L_TRFC) begin
               w_err_hit = 1'b1; w_err_code = E_TIMING;
            end else if (w_is_ar) begin
               w_ar_inc = 1'b1;
            end else if (w_fmt_bad) begin
               w_err_hit = 1'b1; w_err_code = E_MRS_FMT;
            end else begin
               w_mode_ld   = 1'b1;
               w_state_nxt = S_TMRD_WAIT;
            end
         end
         S_TMRD_WAIT: begin
            if (!w_is_nop) begin
               w_err_hit  = 1'b1;
               w_err_code = w_illegal ? E_ILLEGAL : E_TIMING;
            end else if (w_gap_nxt >= L_TMRD) begin
               w_done_set  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_DONE;
         S_ERR:   w_state_nxt = S_ERR;
         default: w_state_nxt = S_EXP_PRE;
      endcase
      if (w_err_hit) w_state_nxt = S_ERR;
   end

   // State register plus power-up and gap counters
   always_ff @(posedge init_clk or negedge init_rst_n) begin
      if (!init_rst_n) begin
         r_state   <= S_EXP_PRE;
         r_pu_cnt  <= 16'd0;
         r_gap_cnt <= 4'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_gap_cnt <= w_gap_nxt;
         if (r_pu_cnt < L_CNT_WAIT) r_pu_cnt <= r_pu_cnt + 16'd1;
      end
   end

   // Registered status: refresh count, sticky error, done and mode fields
   always_ff @(posedge init_clk or negedge init_rst_n) begin
      if (!init_rst_n) begin
         r_ar_cnt     <= 4'd0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_err_code   <= 3'd0;
         r_mode_valid <= 1'b0;
         r_burst_len  <= 3'd0;
         r_burst_type <= 1'b0;
         r_cas_lat    <= 3'd0;
         r_wr_single  <= 1'b0;
      end else begin
         if (w_ar_inc && (r_ar_cnt != 4'hF)) r_ar_cnt <= r_ar_cnt + 4'd1;
         if (w_done_set) r_done <= 1'b1;
         if (w_err_hit) begin
            r_err      <= 1'b1;
            r_err_code <= w_err_code;
         end
         if (w_mode_ld) begin
            r_mode_valid <= 1'b1;
            r_burst_len  <= init_addr[2:0];
            r_burst_type <= init_addr[3];
            r_cas_lat    <= init_addr[6:4];
            r_wr_single  <= init_addr[9];
         end
      end
   end

   assign mon_done       = r_done;
   assign mon_err        = r_err;
   assign mon_err_code   = r_err_code;
   assign mon_ar_cnt     = r_ar_cnt;
   assign mon_mode_valid = r_mode_valid;
   assign mon_burst_len  = r_burst_len;
   assign mon_burst_type = r_burst_type;
   assign mon_cas_lat    = r_cas_lat;
   assign mon_wr_single  = r_wr_single;
   assign mon_state      = r_state;

endmodule

// File: tb/tb_sdram_init_mon.sv
// Bench for sdram_init_mon with a short power-up wait (CNT_WAIT=100).
// Each table record can optionally reset the DUT first. It then holds one
// command for rep edges and compares all outputs against the
// hand-computed values listed in the record.
module tb_sdram_init_mon;

   localparam logic [3:0] NOP = 4'b0111;
   localparam logic [3:0] DES = 4'b1000;
   localparam logic [3:0] PRE = 4'b0010;
   localparam logic [3:0] AR  = 4'b0001;
   localparam logic [3:0] MRS = 4'b0000;
   localparam logic [3:0] WR  = 4'b0100;
   localparam logic [3:0] BAD = 4'b0011;

   logic        clk;
   logic        rst_n;
   logic [3:0]  cmd;
   logic [1:0]  bank;
   logic [12:0] addr;
   logic        done, err, mv, bt, ws;
   logic [2:0]  code, bl, cl, st;
   logic [3:0]  ar;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        rst;
      logic [3:0]  cmd;
      logic [1:0]  bank;
      logic [12:0] addr;
      int          rep;
      logic        e_done;
      logic        e_err;
      logic [2:0]  e_code;
      logic [3:0]  e_ar;
      logic        e_mv;
      logic [7:0]  e_mode;   // {wr_single, cas_lat, burst_type, burst_len}
      string       name;
   } vec_t;

   vec_t vt[$];

   sdram_init_mon #(.CNT_WAIT(100)) dut (
      .init_clk       (clk),
      .init_rst_n     (rst_n),
      .init_cmd       (cmd),
      .init_bank      (bank),
      .init_addr      (addr),
      .mon_done       (done),
      .mon_err        (err),
      .mon_err_code   (code),
      .mon_ar_cnt     (ar),
      .mon_mode_valid (mv),
      .mon_burst_len  (bl),
      .mon_burst_type (bt),
      .mon_cas_lat    (cl),
      .mon_wr_single  (ws),
      .mon_state      (st)
   );

   // Clock and time-limit watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, summary so far %0d applied %0d bad", n_vec, n_err);
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      rst_n = 1'b0; cmd = NOP; bank = 2'd0; addr = 13'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a, input int n);
      for (int i = 0; i < n; i++) begin
         cmd = c; bank = b; addr = a;
         @(negedge clk);
      end
      cmd = NOP; bank = 2'd0; addr = 13'd0;
   endtask

   task automatic check(input string name, input logic e_done, input logic e_err,
                        input logic [2:0] e_code, input logic [3:0] e_ar,
                        input logic e_mv, input logic [7:0] e_mode);
      logic [17:0] act, exp;
      act = {done, err, code, ar, mv, ws, cl, bt, bl};
      exp = {e_done, e_err, e_code, e_ar, e_mv, e_mode};
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got done=%b err=%b code=%0d ar=%0d mv=%b mode=%h, expected done=%b err=%b code=%0d ar=%0d mv=%b mode=%h",
                  name, done, err, code, ar, mv, act[7:0], e_done, e_err, e_code, e_ar, e_mv, e_mode);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                      input int n, input logic e_done, input logic e_err, input logic [2:0] e_code,
                      input logic [3:0] e_ar, input logic e_mv, input logic [7:0] e_mode, input string nm);
      vec_t v;
      v.rst = r; v.cmd = c; v.bank = b; v.addr = a; v.rep = n;
      v.e_done = e_done; v.e_err = e_err; v.e_code = e_code; v.e_ar = e_ar;
      v.e_mv = e_mv; v.e_mode = e_mode; v.name = nm;
      vt.push_back(v);
   endtask

   // Reset, wait out the power-up window, then issue a legal PRE-all at edge 101
   task automatic add_boot(input string s);
      add(1, NOP, 2'd0, 13'h000,   0, 0, 0, 3'd0, 4'd0, 0, 8'h00, {s, "_rst"});
      add(0, NOP, 2'd0, 13'h000, 100, 0, 0, 3'd0, 4'd0, 0, 8'h00, {s, "_wait"});
      add(0, PRE, 2'd0, 13'h400,   1, 0, 0, 3'd0, 4'd0, 0, 8'h00, {s, "_pre"});
   endtask

   // Legal PRE..MRS(0x037) after a fresh reset release, ending two NOPs after MRS
   task automatic legal_seq(input string s);
      drive(NOP, 2'd0, 13'h000, 100);
      drive(PRE, 2'd0, 13'h400, 1);
      drive(NOP, 2'd0, 13'h000, 2);
      drive(AR,  2'd0, 13'h000, 1);
      drive(NOP, 2'd0, 13'h000, 7);
      drive(AR,  2'd0, 13'h000, 1);
      drive(NOP, 2'd0, 13'h000, 7);
      drive(MRS, 2'd0, 13'h037, 1);
      drive(NOP, 2'd0, 13'h000, 2);
      check({s, "_done"}, 1, 0, 3'd0, 4'd2, 1, 8'h37);
   endtask

   initial begin
      rst_n = 1'b0; cmd = NOP; bank = 2'd0; addr = 13'd0;

      // Nominal sequence, then commands ignored once done
      add_boot("nom");
      add(0, NOP, 2'd0, 13'h000, 2, 0, 0, 3'd0, 4'd0, 0, 8'h00, "nom_trp");
      add(0, AR,  2'd0, 13'h000, 1, 0, 0, 3'd0, 4'd1, 0, 8'h00, "nom_ar1");
      add(0, NOP, 2'd0, 13'h000, 7, 0, 0, 3'd0, 4'd1, 0, 8'h00, "nom_trfc1");
      add(0, AR,  2'd0, 13'h000, 1, 0, 0, 3'd0, 4'd2, 0, 8'h00, "nom_ar2");
      add(0, NOP, 2'd0, 13'h000, 7, 0, 0, 3'd0, 4'd2, 0, 8'h00, "nom_trfc2");
      add(0, MRS, 2'd0, 13'h037, 1, 0, 0, 3'd0, 4'd2, 1, 8'h37, "nom_mrs");
      add(0, NOP, 2'd0, 13'h000, 1, 0, 0, 3'd0, 4'd2, 1, 8'h37, "nom_tmrd1");
      add(0, NOP, 2'd0, 13'h000, 1, 1, 0, 3'd0, 4'd2, 1, 8'h37, "nom_done");
      add(0, WR,  2'd0, 13'h000, 1, 1, 0, 3'd0, 4'd2, 1, 8'h37, "nom_ign_wr");
      add(0, AR,  2'd0, 13'h000, 1, 1, 0, 3'd0, 4'd2, 1, 8'h37, "nom_ign_ar");
      add(0, MRS, 2'd3, 13'h1FFF,1, 1, 0, 3'd0, 4'd2, 1, 8'h37, "nom_ign_mrs");

      // PRE at edge 50: early, sticky, never done
      add(1, NOP, 2'd0, 13'h000,  0, 0, 0, 3'd0, 4'd0, 0, 8'h00, "early_rst");
      add(0, NOP, 2'd0, 13'h000, 49, 0, 0, 3'd0, 4'd0, 0, 8'h00, "early_wait");
      add(0, PRE, 2'd0, 13'h400,  1, 0, 1, 3'd2, 4'd0, 0, 8'h00, "early_pre");
      add(0, NOP, 2'd0, 13'h000, 60, 0, 1, 3'd2, 4'd0, 0, 8'h00, "early_hold");
      add(0, PRE, 2'd0, 13'h400,  1, 0, 1, 3'd2, 4'd0, 0, 8'h00, "early_sticky");

      // PRE at edge 100 is one cycle too early
      add(1, NOP, 2'd0, 13'h000,  0, 0, 0, 3'd0, 4'd0, 0, 8'h00, "edge100_rst");
      add(0, NOP, 2'd0, 13'h000, 99, 0, 0, 3'd0, 4'd0, 0, 8'h00, "edge100_wait");
      add(0, PRE, 2'd0, 13'h400,  1, 0, 1, 3'd2, 4'd0, 0, 8'h00, "edge100_pre");

      // Illegal code that is also early: ILLEGAL wins
      add(1, NOP, 2'd0, 13'h000,  0, 0, 0, 3'd0, 4'd0, 0, 8'h00, "ill_rst");
      add(0, NOP, 2'd0, 13'h000, 10, 0, 0, 3'd0, 4'd0, 0, 8'h00, "ill_wait");
      add(0, BAD, 2'd0, 13'h000,  1, 0, 1, 3'd1, 4'd0, 0, 8'h00, "ill_early");

      // PRE without A10
      add(1, NOP, 2'd0, 13'h000,   0, 0, 0, 3'd0, 4'd0, 0, 8'h00, "prea10_rst");
      add(0, NOP, 2'd0, 13'h000, 100, 0, 0, 3'd0, 4'd0, 0, 8'h00, "prea10_wait");
      add(0, PRE, 2'd0, 13'h000,   1, 0, 1, 3'd3, 4'd0, 0, 8'h00, "prea10_pre");

      // tRP violated: one NOP between PRE and AR
      add_boot("trp");
      add(0, NOP, 2'd0, 13'h000, 1, 0, 0, 3'd0, 4'd0, 0, 8'h00, "trp_nop");
      add(0, AR,  2'd0, 13'h000, 1, 0, 1, 3'd4, 4'd0, 0, 8'h00, "trp_ar");

      // MRS straight after PRE
      add_boot("mrspre");
      add(0, NOP, 2'd0, 13'h000, 2, 0, 0, 3'd0, 4'd0, 0, 8'h00, "mrspre_nop");
      add(0, MRS, 2'd0, 13'h037, 1, 0, 1, 3'd3, 4'd0, 0, 8'h00, "mrspre_mrs");

      // tRFC violated: six NOPs between ARs
      add_boot("trfc");
      add(0, NOP, 2'd0, 13'h000, 2, 0, 0, 3'd0, 4'd0, 0, 8'h00, "trfc_nop");
      add(0, AR,  2'd0, 13'h000, 1, 0, 0, 3'd0, 4'd1, 0, 8'h00, "trfc_ar1");
      add(0, NOP, 2'd0, 13'h000, 6, 0, 0, 3'd0, 4'd1, 0, 8'h00, "trfc_gap");
      add(0, AR,  2'd0, 13'h000, 1, 0, 1, 3'd4, 4'd1, 0, 8'h00, "trfc_ar2");

      // MRS after a single AR
      add_boot("onear");
      add(0, NOP, 2'd0, 13'h000, 2, 0, 0, 3'd0, 4'd0, 0, 8'h00, "onear_nop");
      add(0, AR,  2'd0, 13'h000, 1, 0, 0, 3'd0, 4'd1, 0, 8'h00, "onear_ar");
      add(0, NOP, 2'd0, 13'h000, 7, 0, 0, 3'd0, 4'd1, 0, 8'h00, "onear_gap");
      add(0, MRS, 2'd0, 13'h037, 1, 0, 1, 3'd3, 4'd1, 0, 8'h00, "onear_mrs");

      // MRS with bank=01: format error, mode not latched
      add_boot("fmt");
      add(0, NOP, 2'd0, 13'h000, 2, 0, 0, 3'd0, 4'd0, 0, 8'h00, "fmt_nop");
      add(0, AR,  2'd0, 13'h000, 1, 0, 0, 3'd0, 4'd1, 0, 8'h00, "fmt_ar1");
      add(0, NOP, 2'd0, 13'h000, 7, 0, 0, 3'd0, 4'd1, 0, 8'h00, "fmt_gap1");
      add(0, AR,  2'd0, 13'h000, 1, 0, 0, 3'd0, 4'd2, 0, 8'h00, "fmt_ar2");
      add(0, NOP, 2'd0, 13'h000, 7, 0, 0, 3'd0, 4'd2, 0, 8'h00, "fmt_gap2");
      add(0, MRS, 2'd1, 13'h037, 1, 0, 1, 3'd5, 4'd2, 0, 8'h00, "fmt_mrs");

      // Write inside AR_LOOP (also too soon): ILLEGAL, then sticky
      add_boot("wr");
      add(0, NOP, 2'd0, 13'h000, 2, 0, 0, 3'd0, 4'd0, 0, 8'h00, "wr_nop");
      add(0, AR,  2'd0, 13'h000, 1, 0, 0, 3'd0, 4'd1, 0, 8'h00, "wr_ar");
      add(0, NOP, 2'd0, 13'h000, 3, 0, 0, 3'd0, 4'd1, 0, 8'h00, "wr_gap");
      add(0, WR,  2'd0, 13'h000, 1, 0, 1, 3'd1, 4'd1, 0, 8'h00, "wr_wr");
      add(0, NOP, 2'd0, 13'h000, 5, 0, 1, 3'd1, 4'd1, 0, 8'h00, "wr_hold");
      add(0, PRE, 2'd0, 13'h400, 1, 0, 1, 3'd1, 4'd1, 0, 8'h00, "wr_sticky");

      // Three ARs, deselect used as idle, MRS 0x22A
      add_boot("ar3");
      add(0, DES, 2'd0, 13'h000, 2, 0, 0, 3'd0, 4'd0, 0, 8'h00, "ar3_des0");
      add(0, AR,  2'd0, 13'h000, 1, 0, 0, 3'd0, 4'd1, 0, 8'h00, "ar3_ar1");
      add(0, DES, 2'd0, 13'h000, 7, 0, 0, 3'd0, 4'd1, 0, 8'h00, "ar3_des1");
      add(0, AR,  2'd0, 13'h000, 1, 0, 0, 3'd0, 4'd2, 0, 8'h00, "ar3_ar2");
      add(0, DES, 2'd0, 13'h000, 7, 0, 0, 3'd0, 4'd2, 0, 8'h00, "ar3_des2");
      add(0, AR,  2'd0, 13'h000, 1, 0, 0, 3'd0, 4'd3, 0, 8'h00, "ar3_ar3");
      add(0, DES, 2'd0, 13'h000, 7, 0, 0, 3'd0, 4'd3, 0, 8'h00, "ar3_des3");
      add(0, MRS, 2'd0, 13'h22A, 1, 0, 0, 3'd0, 4'd3, 1, 8'hAA, "ar3_mrs");
      add(0, NOP, 2'd0, 13'h000, 2, 1, 0, 3'd0, 4'd3, 1, 8'hAA, "ar3_done");

      // Command during the tMRD wait
      add_boot("tmrd");
      add(0, NOP, 2'd0, 13'h000, 2, 0, 0, 3'd0, 4'd0, 0, 8'h00, "tmrd_nop");
      add(0, AR,  2'd0, 13'h000, 1, 0, 0, 3'd0, 4'd1, 0, 8'h00, "tmrd_ar1");
      add(0, NOP, 2'd0, 13'h000, 7, 0, 0, 3'd0, 4'd1, 0, 8'h00, "tmrd_gap1");
      add(0, AR,  2'd0, 13'h000, 1, 0, 0, 3'd0, 4'd2, 0, 8'h00, "tmrd_ar2");
      add(0, NOP, 2'd0, 13'h000, 7, 0, 0, 3'd0, 4'd2, 0, 8'h00, "tmrd_gap2");
      add(0, MRS, 2'd0, 13'h037, 1, 0, 0, 3'd0, 4'd2, 1, 8'h37, "tmrd_mrs");
      add(0, NOP, 2'd0, 13'h000, 1, 0, 0, 3'd0, 4'd2, 1, 8'h37, "tmrd_nop1");
      add(0, AR,  2'd0, 13'h000, 1, 0, 1, 3'd4, 4'd2, 1, 8'h37, "tmrd_ar");

      foreach (vt[i]) begin
         if (vt[i].rst) do_reset();
         drive(vt[i].cmd, vt[i].bank, vt[i].addr, vt[i].rep);
         check(vt[i].name, vt[i].e_done, vt[i].e_err, vt[i].e_code, vt[i].e_ar, vt[i].e_mv, vt[i].e_mode);
      end

      // Asynchronous reset in the middle of AR_LOOP, then a full legal run
      do_reset();
      drive(NOP, 2'd0, 13'h000, 100);
      drive(PRE, 2'd0, 13'h400, 1);
      drive(NOP, 2'd0, 13'h000, 2);
      drive(AR,  2'd0, 13'h000, 1);
      check("mid_pre_rst", 0, 0, 3'd0, 4'd1, 0, 8'h00);
      #2 rst_n = 1'b0;
      #1 check("mid_async_rst", 0, 0, 3'd0, 4'd0, 0, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      legal_seq("mid_after");

      // Another mid-run reset: power-up counter must restart from zero
      #2 rst_n = 1'b0;
      #1 check("done_async_rst", 0, 0, 3'd0, 4'd0, 0, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      drive(NOP, 2'd0, 13'h000, 99);
      drive(PRE, 2'd0, 13'h400, 1);
      check("pu_restart", 0, 1, 3'd2, 4'd0, 0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
